mips_data_bus_bridge: RTL and testbench
=======================================

# mips_data_bus_bridge

Bridges the CPU's data port (combinational read, single-cycle write) to an external memory bus with a `waitrequest` handshake. The block sits directly downstream of the MIPS Harvard CPU core, on its data-memory side. It stalls the core by gating the core's `clk_enable` while a bus transaction is outstanding. It returns registered read data to the core once the bus completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum bus wait cycles before abort; 0 disables the timeout.
- `ERR_READDATA`, default 32'hDEADBEEF: data returned to the CPU on a timed-out read.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clk_enable_in`  in  1  global enable from the testbench/system.
- `cpu_clk_enable`  out  1  enable to the CPU core's `clk_enable`.
- `cpu_data_read`  in  1  CPU load request.
- `cpu_data_write`  in  1  CPU store request.
- `cpu_data_address`  in  32  CPU byte address.
- `cpu_data_writedata`  in  32  CPU store data.
- `cpu_data_readdata`  out  32  load data returned to the CPU.
- `avm_address`  out  32  bus address, word-aligned: {cpu_data_address[31:2], 2'b00}.
- `avm_read`  out  1  bus read strobe, registered.
- `avm_write`  out  1  bus write strobe, registered.
- `avm_writedata`  out  32  bus write data, registered.
- `avm_byteenable`  out  4  constant 4'b1111 while a strobe is high, otherwise 0.
- `avm_readdata`  in  32  bus read data; valid in a cycle where `avm_read`=1 and `avm_waitrequest`=0.
- `avm_waitrequest`  in  1  bus stall.
- `bus_error`  out  1  sticky flag for a timeout or a simultaneous read+write; cleared only by reset.

## Operation
The block is a three-state FSM: IDLE, BUS, DONE.

IDLE:
- `cpu_clk_enable` = `clk_enable_in` & ~(`cpu_data_read` | `cpu_data_write`).
- A request with `clk_enable_in`=1 registers the address, write data and strobe, then moves to BUS.
- Requests are ignored while `clk_enable_in`=0.
- Read and write both high: the write takes priority and `bus_error` is set.

BUS:
- `cpu_clk_enable`=0; the strobe is held and the wait counter is active.
- `avm_waitrequest`=0:
  - drop the strobe;
  - on a read, capture `avm_readdata` into `cpu_data_readdata`;
  - move to DONE.
- `avm_waitrequest`=1: the counter increments.
  - If the counter equals `TIMEOUT_CYCLES` (and `TIMEOUT_CYCLES` is nonzero): drop the strobe, set `bus_error`, load `ERR_READDATA` on a read (a write is silently discarded), move to DONE.

DONE:
- `cpu_clk_enable` = `clk_enable_in`.
- `cpu_data_readdata` holds the captured value.
- `clk_enable_in`=1: the CPU consumes the result on this edge; return to IDLE and clear the counter.
- `clk_enable_in`=0: stay in DONE.

General rules:
- The counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- `cpu_data_readdata` changes only on capture, timeout or reset. It is stable throughout DONE.
- CPU request signals are not re-sampled in BUS or DONE. The CPU is frozen, so its inputs are stable.
- At most one bus transaction is outstanding; there is no pipelining.

## Timing
Reset values, applied asynchronously when `reset`=0:
- state IDLE;
- `cpu_clk_enable`=0, `avm_read`=0, `avm_write`=0;
- `avm_address`=0, `avm_writedata`=0, `avm_byteenable`=0;
- `cpu_data_readdata`=0, `bus_error`=0, counter 0.

Latency with a zero-wait bus:
- request seen in cycle 0;
- strobe high in cycle 1, where the bus completes;
- DONE in cycle 2, with `cpu_clk_enable`=1.
- The CPU therefore sees 2 stalled cycles plus 1 enabled cycle per access.
- Each `waitrequest` cycle adds 1 cycle.

Handshake and reset rules:
- Bus strobes are registered outputs. Address and data are stable for the whole strobe.
- Reset mid-transaction drops the strobes immediately, because the reset is asynchronous. No completion is reported.

## Test plan
- Read, zero-wait: address 0x1004, bus returns 0x12345678 in the first strobe cycle -> `avm_read` high for exactly 1 cycle; `cpu_clk_enable` low 2 cycles, then high 1; `cpu_data_readdata`=0x12345678 in DONE.
- Write with 3 waitrequest cycles: address 0x2003, data 0xCAFEF00D -> `avm_write` high 4 cycles; `avm_address`=0x2000; `avm_byteenable`=4'b1111; `cpu_clk_enable` low 5 cycles, then high 1.
- Timeout with `TIMEOUT_CYCLES`=4 and `waitrequest` stuck high on a read -> strobe dropped after 4 wait cycles; `bus_error`=1; `cpu_data_readdata`=0xDEADBEEF; the CPU is released.
- Simultaneous read+write at 0x0 -> a bus write is issued with no bus read; `bus_error`=1 and stays 1 until reset.
- `clk_enable_in` driven low while in DONE for 3 cycles -> state stays DONE, `cpu_clk_enable`=0, readdata held; IDLE on the first cycle with `clk_enable_in`=1.
- Reset asserted during BUS with `avm_read`=1 -> `avm_read`, `cpu_clk_enable` and `cpu_data_readdata` go to 0 immediately; after release, the next request issues a clean transaction.

Source files
------------

// File: rtl/mips_data_bus_bridge.sv
// ---------------------------------------------------------------------------
// mips_data_bus_bridge
//
// Connects the data port of the MIPS Harvard core to an external memory bus
// that uses a waitrequest handshake. The core expects a load to finish in the
// same cycle and a store to finish in one cycle. This bridge makes that work
// with a slower bus: it freezes the core through cpu_clk_enable for as long as
// a bus transaction is outstanding. Load data is returned in a register that
// stays stable until the core has consumed it.
//
// Parameters
//   TIMEOUT_CYCLES     number of waitrequest cycles tolerated before the
//                      transaction is abandoned (0 = wait forever)
//   ERR_READDATA       value handed to the core when a load times out
//
// Ports
//   clk                system clock, rising-edge active
//   reset              asynchronous reset, active low
//   clk_enable_in      global enable from the system
//   cpu_clk_enable     enable forwarded to the core's clk_enable
//   cpu_data_read      core load request
//   cpu_data_write     core store request
//   cpu_data_address   core byte address
//   cpu_data_writedata core store data
//   cpu_data_readdata  load data returned to the core (registered)
//   avm_address        word-aligned bus address (registered)
//   avm_read           bus read strobe (registered)
//   avm_write          bus write strobe (registered)
//   avm_writedata      bus write data (registered)
//   avm_byteenable     all lanes enabled while a strobe is high
//   avm_readdata       bus read data
//   avm_waitrequest    bus stall
//   bus_error          sticky timeout / read+write collision flag
// ---------------------------------------------------------------------------
module mips_data_bus_bridge #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_READDATA   = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable_in,
   output logic        cpu_clk_enable,
   input  logic        cpu_data_read,
   input  logic        cpu_data_write,
   input  logic [31:0] cpu_data_address,
   input  logic [31:0] cpu_data_writedata,
   output logic [31:0] cpu_data_readdata,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        bus_error
);

   // A timeout of 0 still needs a legal, non-zero counter width.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   // The abort fires on the wait cycle that brings the count up to
   // TIMEOUT_CYCLES, so it is compared against the count before that increment.
   localparam logic [CNT_W-1:0] LAST_WAIT =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] wait_cnt;
   logic             cpu_req;
   logic             accept;
   logic             complete;
   logic             timeout_hit;

   assign cpu_req = cpu_data_read | cpu_data_write;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and the core enable. In IDLE the enable has to drop in
   // the same cycle a request appears. The core's load/store therefore never
   // "completes" on its own, and it stays frozen until DONE. cpu_clk_enable is
   // combinational, so it is also forced low while reset is asserted.
   always_comb begin
      state_d        = state_q;
      cpu_clk_enable = 1'b0;
      accept         = 1'b0;
      complete       = 1'b0;
      timeout_hit    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cpu_clk_enable = clk_enable_in & ~cpu_req;
            if (clk_enable_in && cpu_req) begin
               accept  = 1'b1;
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            if (!avm_waitrequest) begin
               complete = 1'b1;
               state_d  = ST_DONE;
            end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == LAST_WAIT)) begin
               timeout_hit = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            cpu_clk_enable = clk_enable_in;
            if (clk_enable_in) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (!reset) begin
         cpu_clk_enable = 1'b0;
      end
   end

   // Bus-side registers. These are loaded when a request is accepted and held
   // for the whole strobe. When read and write arrive together, the write wins
   // and the collision is recorded in bus_error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         avm_address    <= 32'h0;
         avm_writedata  <= 32'h0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_byteenable <= 4'h0;
      end else if (accept) begin
         avm_address    <= {cpu_data_address[31:2], 2'b00};
         avm_writedata  <= cpu_data_writedata;
         avm_read       <= cpu_data_read & ~cpu_data_write;
         avm_write      <= cpu_data_write;
         avm_byteenable <= 4'hF;
      end else if (complete || timeout_hit) begin
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_byteenable <= 4'h0;
      end
   end

   // Load data returned to the core. It changes only when a read completes
   // or times out, so it stays stable for as long as the FSM sits in DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_data_readdata <= 32'h0;
      end else if (complete && avm_read) begin
         cpu_data_readdata <= avm_readdata;
      end else if (timeout_hit && avm_read) begin
         cpu_data_readdata <= ERR_READDATA;
      end
   end

   // Sticky error flag. Only reset can clear it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_error <= 1'b0;
      end else if ((accept && cpu_data_read && cpu_data_write) || timeout_hit) begin
         bus_error <= 1'b1;
      end
   end

   // Wait counter. It saturates instead of wrapping, so that with the timeout
   // disabled a long stall cannot make it fold back. It is cleared when the
   // core consumes the result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (state_q == ST_DONE && clk_enable_in) begin
         wait_cnt <= '0;
      end else if (state_q == ST_BUS && avm_waitrequest && wait_cnt != CNT_MAX) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_mips_data_bus_bridge
//
// Directed testbench for mips_data_bus_bridge, using a 4-cycle timeout.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled on the falling edge. Every expected value below is worked out by
// hand from the bridge's cycle-level behaviour.
// ---------------------------------------------------------------------------
module tb_mips_data_bus_bridge;

   logic        clk;
   logic        reset;
   logic        clk_enable_in;
   logic        cpu_clk_enable;
   logic        cpu_data_read;
   logic        cpu_data_write;
   logic [31:0] cpu_data_address;
   logic [31:0] cpu_data_writedata;
   logic [31:0] cpu_data_readdata;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        bus_error;

   int error_count;
   int check_count;

   mips_data_bus_bridge #(
      .TIMEOUT_CYCLES (4),
      .ERR_READDATA   (32'hDEADBEEF)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .clk_enable_in      (clk_enable_in),
      .cpu_clk_enable     (cpu_clk_enable),
      .cpu_data_read      (cpu_data_read),
      .cpu_data_write     (cpu_data_write),
      .cpu_data_address   (cpu_data_address),
      .cpu_data_writedata (cpu_data_writedata),
      .cpu_data_readdata  (cpu_data_readdata),
      .avm_address        (avm_address),
      .avm_read           (avm_read),
      .avm_write          (avm_write),
      .avm_writedata      (avm_writedata),
      .avm_byteenable     (avm_byteenable),
      .avm_readdata       (avm_readdata),
      .avm_waitrequest    (avm_waitrequest),
      .bus_error          (bus_error)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and report any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive all CPU-side and bus-side inputs in one go.
   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic ce, input logic wreq,
                                input logic [31:0] rdata);
      cpu_data_read      = rd;
      cpu_data_write     = wr;
      cpu_data_address   = addr;
      cpu_data_writedata = wdata;
      clk_enable_in      = ce;
      avm_waitrequest    = wreq;
      avm_readdata       = rdata;
   endtask

   // Move to the drive point of the next cycle.
   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   // Stimulus sequence.
   initial begin
      error_count = 0;
      check_count = 0;
      reset       = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);

      // Reset state.
      #3;
      checkOutput("rst_cke",   cpu_clk_enable, 32'h0);
      checkOutput("rst_read",  avm_read, 32'h0);
      checkOutput("rst_write", avm_write, 32'h0);
      checkOutput("rst_addr",  avm_address, 32'h0);
      checkOutput("rst_wdata", avm_writedata, 32'h0);
      checkOutput("rst_be",    avm_byteenable, 32'h0);
      checkOutput("rst_rdata", cpu_data_readdata, 32'h0);
      checkOutput("rst_err",   bus_error, 32'h0);
      #9 reset = 1'b1;
      nextCycle;

      // Zero-wait read from 0x1004.
      applyStimulus(1'b1, 1'b0, 32'h1004, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("rd_c0_cke",  cpu_clk_enable, 32'h0);
      checkOutput("rd_c0_read", avm_read, 32'h0);
      nextCycle;
      applyStimulus(1'b1, 1'b0, 32'h1004, 32'h0, 1'b1, 1'b0, 32'h12345678);
      @(negedge clk);
      checkOutput("rd_c1_read", avm_read, 32'h1);
      checkOutput("rd_c1_addr", avm_address, 32'h1004);
      checkOutput("rd_c1_be",   avm_byteenable, 32'hF);
      checkOutput("rd_c1_cke",  cpu_clk_enable, 32'h0);
      nextCycle;
      applyStimulus(1'b1, 1'b0, 32'h1004, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("rd_c2_read",  avm_read, 32'h0);
      checkOutput("rd_c2_cke",   cpu_clk_enable, 32'h1);
      checkOutput("rd_c2_rdata", cpu_data_readdata, 32'h12345678);
      nextCycle;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("rd_c3_cke", cpu_clk_enable, 32'h1);
      nextCycle;

      // Write to 0x2003 with three waitrequest cycles.
      applyStimulus(1'b0, 1'b1, 32'h2003, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("wr_c0_cke", cpu_clk_enable, 32'h0);
      nextCycle;
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b0, 1'b1, 32'h2003, 32'hCAFEF00D, 1'b1, (k <= 3), 32'h0);
         @(negedge clk);
         checkOutput($sformatf("wr_c%0d_write", k), avm_write, 32'h1);
         checkOutput($sformatf("wr_c%0d_cke", k), cpu_clk_enable, 32'h0);
         checkOutput($sformatf("wr_c%0d_addr", k), avm_address, 32'h2000);
         checkOutput($sformatf("wr_c%0d_wdata", k), avm_writedata, 32'hCAFEF00D);
         checkOutput($sformatf("wr_c%0d_be", k), avm_byteenable, 32'hF);
         nextCycle;
      end
      @(negedge clk);
      checkOutput("wr_c5_write", avm_write, 32'h0);
      checkOutput("wr_c5_be",    avm_byteenable, 32'h0);
      checkOutput("wr_c5_cke",   cpu_clk_enable, 32'h1);
      checkOutput("wr_c5_rdata", cpu_data_readdata, 32'h12345678);
      nextCycle;

      // Read at 0x40, then hold in DONE with clk_enable_in low for three cycles.
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      nextCycle;
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'hA5A50001);
      @(negedge clk);
      checkOutput("hold_read", avm_read, 32'h1);
      nextCycle;
      for (int j = 0; j < 3; j++) begin
         applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
         @(negedge clk);
         checkOutput($sformatf("hold%0d_cke", j), cpu_clk_enable, 32'h0);
         checkOutput($sformatf("hold%0d_rdata", j), cpu_data_readdata, 32'hA5A50001);
         checkOutput($sformatf("hold%0d_read", j), avm_read, 32'h0);
         nextCycle;
      end
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("hold_rel_cke",   cpu_clk_enable, 32'h1);
      checkOutput("hold_rel_rdata", cpu_data_readdata, 32'hA5A50001);
      nextCycle;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("hold_idle_cke", cpu_clk_enable, 32'h1);
      nextCycle;

      // Read with waitrequest stuck high, ending in a timeout after 4 wait cycles.
      applyStimulus(1'b1, 1'b0, 32'h3000, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF);
      @(negedge clk);
      nextCycle;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("to_c%0d_read", k), avm_read, 32'h1);
         checkOutput($sformatf("to_c%0d_err", k), bus_error, 32'h0);
         checkOutput($sformatf("to_c%0d_cke", k), cpu_clk_enable, 32'h0);
         nextCycle;
      end
      @(negedge clk);
      checkOutput("to_c5_read",  avm_read, 32'h0);
      checkOutput("to_c5_err",   bus_error, 32'h1);
      checkOutput("to_c5_rdata", cpu_data_readdata, 32'hDEADBEEF);
      checkOutput("to_c5_cke",   cpu_clk_enable, 32'h1);
      nextCycle;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      nextCycle;

      // Reset asserted while a read strobe is on the bus.
      applyStimulus(1'b1, 1'b0, 32'h5000, 32'h0, 1'b1, 1'b1, 32'h0);
      @(negedge clk);
      nextCycle;
      @(negedge clk);
      checkOutput("mr_pre_read",  avm_read, 32'h1);
      checkOutput("mr_pre_rdata", cpu_data_readdata, 32'hDEADBEEF);
      #2 reset = 1'b0;
      #1;
      checkOutput("mr_read",  avm_read, 32'h0);
      checkOutput("mr_cke",   cpu_clk_enable, 32'h0);
      checkOutput("mr_rdata", cpu_data_readdata, 32'h0);
      checkOutput("mr_err",   bus_error, 32'h0);
      @(posedge clk);
      #2 reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      nextCycle;

      // Clean read after reset.
      applyStimulus(1'b1, 1'b0, 32'h5008, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      nextCycle;
      applyStimulus(1'b1, 1'b0, 32'h5008, 32'h0, 1'b1, 1'b0, 32'h0BADF00D);
      @(negedge clk);
      checkOutput("pr_read", avm_read, 32'h1);
      checkOutput("pr_addr", avm_address, 32'h5008);
      nextCycle;
      @(negedge clk);
      checkOutput("pr_rdata", cpu_data_readdata, 32'h0BADF00D);
      checkOutput("pr_cke",   cpu_clk_enable, 32'h1);
      nextCycle;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      nextCycle;

      // Read and write together at 0x0: the write wins and the error is sticky.
      applyStimulus(1'b1, 1'b1, 32'h0, 32'h11112222, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("rw_c0_cke", cpu_clk_enable, 32'h0);
      nextCycle;
      @(negedge clk);
      checkOutput("rw_c1_write", avm_write, 32'h1);
      checkOutput("rw_c1_read",  avm_read, 32'h0);
      checkOutput("rw_c1_wdata", avm_writedata, 32'h11112222);
      checkOutput("rw_c1_err",   bus_error, 32'h1);
      nextCycle;
      @(negedge clk);
      checkOutput("rw_c2_cke",   cpu_clk_enable, 32'h1);
      checkOutput("rw_c2_rdata", cpu_data_readdata, 32'h0BADF00D);
      nextCycle;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      nextCycle;
      applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h00000077);
      @(negedge clk);
      nextCycle;
      @(negedge clk);
      checkOutput("rw_next_read", avm_read, 32'h1);
      checkOutput("rw_next_addr", avm_address, 32'h8);
      nextCycle;
      @(negedge clk);
      checkOutput("rw_next_rdata", cpu_data_readdata, 32'h00000077);
      checkOutput("rw_next_err",   bus_error, 32'h1);
      nextCycle;

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
